// File: rtl/ssd1331_spi_receiver.sv
// ssd1331_spi_receiver: display-side SPI receiver, SSD1331 command decoder and
// frame-buffer pixel write generator with window auto-increment.
module ssd1331_spi_receiver #(
  parameter int WIDTH        = 8,
  parameter int NUM_COL      = 96,
  parameter int NUM_ROW      = 64,
  parameter int N_COLOR_BITS = 8,
  parameter int ADDR_W       = 13
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic                    i_SCK,
  input  logic                    i_MOSI,
  input  logic                    i_CS,
  input  logic                    i_DC,
  input  logic                    i_RES,
  output logic                    o_BYTE_VALID,
  output logic [WIDTH-1:0]        o_BYTE,
  output logic                    o_BYTE_DC,
  output logic                    o_WR_EN,
  output logic [ADDR_W-1:0]       o_WR_ADDR,
  output logic [N_COLOR_BITS-1:0] o_WR_DATA,
  output logic                    o_DISPLAY_ON,
  output logic [7:0]              o_REMAP,
  output logic                    o_ERR
);
  localparam int CW = $clog2(NUM_COL);
  localparam int RW = $clog2(NUM_ROW);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] COL_MAX = CW'(NUM_COL - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(NUM_ROW - 1);
  typedef enum logic [2:0] {CMD, COL_A, COL_B, ROW_A, ROW_B, REMAP_A} state_t;
  state_t state;
  logic [1:0] sck_sy, mosi_sy, cs_sy, dc_sy;
  logic sck_p;
  logic [WIDTH-2:0] sh;
  logic [BW-1:0] cnt;
  logic [WIDTH-1:0] arg;
  logic [CW-1:0] col, col_start, col_end, col_nx, c_lo, c_hi;
  logic [RW-1:0] row, row_start, row_end, row_nx, r_lo, r_hi;
  logic [ADDR_W-1:0] addr;
  logic rise;
  function automatic logic [CW-1:0] clamp_c(input logic [WIDTH-1:0] v);
    return (int'(v) > NUM_COL - 1) ? COL_MAX : CW'(v);
  endfunction
  function automatic logic [RW-1:0] clamp_r(input logic [WIDTH-1:0] v);
    return (int'(v) > NUM_ROW - 1) ? ROW_MAX : RW'(v);
  endfunction
  assign rise = sck_sy[1] & ~sck_p;
  assign c_lo = clamp_c(arg);
  assign c_hi = clamp_c(o_BYTE);
  assign r_lo = clamp_r(arg);
  assign r_hi = clamp_r(o_BYTE);
  assign addr = ADDR_W'(row) * ADDR_W'(NUM_COL) + ADDR_W'(col);
  // Column wraps to window start at its end, carrying into the row which wraps the same way.
  assign col_nx = (col == col_end) ? col_start : col + CW'(1);
  assign row_nx = (col != col_end) ? row : (row == row_end) ? row_start : row + RW'(1);
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      sck_sy <= '0; mosi_sy <= '0; cs_sy <= '0; dc_sy <= '0; sck_p <= 1'b0;
      sh <= '0; cnt <= '0; arg <= '0; state <= CMD;
      col <= '0; col_start <= '0; col_end <= COL_MAX;
      row <= '0; row_start <= '0; row_end <= ROW_MAX;
      o_BYTE_VALID <= 1'b0; o_BYTE <= '0; o_BYTE_DC <= 1'b0;
      o_WR_EN <= 1'b0; o_WR_ADDR <= '0; o_WR_DATA <= '0;
      o_DISPLAY_ON <= 1'b0; o_REMAP <= '0; o_ERR <= 1'b0;
    end else if (!i_RES) begin
      sck_sy <= '0; mosi_sy <= '0; cs_sy <= '0; dc_sy <= '0; sck_p <= 1'b0;
      sh <= '0; cnt <= '0; arg <= '0; state <= CMD;
      col <= '0; col_start <= '0; col_end <= COL_MAX;
      row <= '0; row_start <= '0; row_end <= ROW_MAX;
      o_BYTE_VALID <= 1'b0; o_BYTE <= '0; o_BYTE_DC <= 1'b0;
      o_WR_EN <= 1'b0; o_WR_ADDR <= '0; o_WR_DATA <= '0;
      o_DISPLAY_ON <= 1'b0; o_REMAP <= '0; o_ERR <= 1'b0;
    end else begin
      sck_sy <= {sck_sy[0], i_SCK};
      mosi_sy <= {mosi_sy[0], i_MOSI};
      cs_sy <= {cs_sy[0], i_CS};
      dc_sy <= {dc_sy[0], i_DC};
      sck_p <= sck_sy[1];
      o_BYTE_VALID <= 1'b0;
      o_WR_EN <= 1'b0;
      o_ERR <= 1'b0;
      if (cs_sy[1]) begin
        cnt <= '0;
      end else if (rise) begin
        sh <= {sh[WIDTH-3:0], mosi_sy[1]};
        cnt <= (cnt == BW'(WIDTH - 1)) ? '0 : cnt + BW'(1);
        if (cnt == BW'(WIDTH - 1)) begin
          o_BYTE_VALID <= 1'b1;
          o_BYTE <= {sh, mosi_sy[1]};
          o_BYTE_DC <= dc_sy[1];
        end
      end
      // A data byte is always a pixel; arriving mid-command it also aborts that command.
      if (o_BYTE_VALID && o_BYTE_DC) begin
        o_WR_EN <= 1'b1;
        o_WR_DATA <= N_COLOR_BITS'(o_BYTE);
        o_WR_ADDR <= addr;
        col <= col_nx;
        row <= row_nx;
        o_ERR <= (state != CMD);
        state <= CMD;
      end else if (o_BYTE_VALID) begin
        case (state)
          CMD: begin
            case (o_BYTE)
              8'h15: state <= COL_A;
              8'h75: state <= ROW_A;
              8'hA0: state <= REMAP_A;
              8'hAF: o_DISPLAY_ON <= 1'b1;
              8'hAE: o_DISPLAY_ON <= 1'b0;
              default: o_ERR <= 1'b1;
            endcase
          end
          COL_A: begin
            arg <= o_BYTE;
            state <= COL_B;
          end
          COL_B: begin
            state <= CMD;
            if (c_lo > c_hi) o_ERR <= 1'b1;
            else begin
              col_start <= c_lo;
              col_end <= c_hi;
              col <= c_lo;
            end
          end
          ROW_A: begin
            arg <= o_BYTE;
            state <= ROW_B;
          end
          ROW_B: begin
            state <= CMD;
            if (r_lo > r_hi) o_ERR <= 1'b1;
            else begin
              row_start <= r_lo;
              row_end <= r_hi;
              row <= r_lo;
            end
          end
          REMAP_A: begin
            o_REMAP <= 8'(o_BYTE);
            state <= CMD;
          end
          default: state <= CMD;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ssd1331_spi_receiver.sv
// tb_ssd1331_spi_receiver: directed + randomized SPI traffic checked against a
// byte-level behavioural model of the SSD1331 command/pixel rules.
module tb_ssd1331_spi_receiver;
  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, mosi = 1'b0, cs = 1'b1, dc = 1'b0, res = 1'b1;
  logic bv, bdc, wr_en, disp_on, err;
  logic [7:0] bt, wr_data, remap;
  logic [12:0] wr_addr;
  logic [8:0] bq[$];
  logic [20:0] wq[$];
  int n_err = 0, n_tests = 0, n_fail = 0, last_addr = -1;
  int m_cs, m_ce, m_rs, m_re, m_pc, m_pr, m_disp, m_remap, m_cmd;
  int m_args[$];

  ssd1331_spi_receiver dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_SCK(sck), .i_MOSI(mosi), .i_CS(cs), .i_DC(dc),
    .i_RES(res), .o_BYTE_VALID(bv), .o_BYTE(bt), .o_BYTE_DC(bdc), .o_WR_EN(wr_en),
    .o_WR_ADDR(wr_addr), .o_WR_DATA(wr_data), .o_DISPLAY_ON(disp_on), .o_REMAP(remap),
    .o_ERR(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bv) bq.push_back({bdc, bt});
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (err) n_err++;
  end

  initial begin
    #3ms;
    $display("FAIL timeout: got no finish, expected finish within 3ms");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_cs = 0; m_ce = 95; m_rs = 0; m_re = 63; m_pc = 0; m_pr = 0;
    m_disp = 0; m_remap = 0; m_cmd = 0;
    m_args.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_byte_valid"}, bv, 0);
    check({tag, "_byte"}, bt, 0);
    check({tag, "_byte_dc"}, bdc, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_display_on"}, disp_on, 0);
    check({tag, "_remap"}, remap, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic send_bits(input logic d, input logic [7:0] b, input int n);
    cs = 1'b0;
    dc = d;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic partial(input int n);
    send_bits(1'b0, 8'($urandom), n);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check("partial_no_byte", bq.size(), 0);
    check("partial_no_write", wq.size(), 0);
    check("partial_no_err", n_err, 0);
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic xfer(input logic d, input logic [7:0] b);
    int e_err = 0, e_wr = 0, e_addr = 0, s, e, mx;
    logic [20:0] w;
    if (d) begin
      e_err = (m_cmd != 0);
      m_cmd = 0;
      m_args.delete();
      e_wr = 1;
      e_addr = m_pr * 96 + m_pc;
      if (m_pc == m_ce) begin
        m_pc = m_cs;
        m_pr = (m_pr == m_re) ? m_rs : m_pr + 1;
      end else m_pc++;
    end else if (m_cmd == 0) begin
      if (b == 8'h15 || b == 8'h75 || b == 8'hA0) m_cmd = b;
      else if (b == 8'hAF) m_disp = 1;
      else if (b == 8'hAE) m_disp = 0;
      else e_err = 1;
    end else begin
      m_args.push_back(b);
      if (m_cmd == 8'hA0) begin
        m_remap = b;
        m_cmd = 0;
        m_args.delete();
      end else if (m_args.size() == 2) begin
        mx = (m_cmd == 8'h15) ? 95 : 63;
        s = (m_args[0] > mx) ? mx : m_args[0];
        e = (m_args[1] > mx) ? mx : m_args[1];
        if (s > e) e_err = 1;
        else if (m_cmd == 8'h15) begin m_cs = s; m_ce = e; m_pc = s; end
        else begin m_rs = s; m_re = e; m_pr = s; end
        m_cmd = 0;
        m_args.delete();
      end
    end
    send_bits(d, b, 8);
    repeat (6) @(negedge clk);
    check("byte_cnt", bq.size(), 1);
    if (bq.size() > 0) check("byte", int'(bq.pop_front()), int'({d, b}));
    check("err", n_err, e_err);
    check("wr_cnt", wq.size(), e_wr);
    if (wq.size() > 0) begin
      w = wq.pop_front();
      last_addr = int'(w[20:8]);
      check("wr_addr", last_addr, e_addr);
      check("wr_data", int'(w[7:0]), int'(b));
    end
    check("display_on", disp_on, m_disp);
    check("remap", remap, m_remap);
    n_err = 0;
    bq.delete();
    wq.delete();
  endtask

  task automatic flush();
    bq.delete();
    wq.delete();
    n_err = 0;
  endtask

  initial begin
    int r;
    logic [7:0] cmds[6];
    cmds = '{8'h15, 8'h75, 8'hA0, 8'hAF, 8'hAE, 8'h00};
    m_reset();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    xfer(1'b0, 8'hAF);
    check("display_on_after_af", disp_on, 1);
    xfer(1'b0, 8'h15); xfer(1'b0, 8'h08); xfer(1'b0, 8'h0F);
    xfer(1'b0, 8'h75); xfer(1'b0, 8'h10); xfer(1'b0, 8'h17);
    for (int i = 0; i < 65; i++) begin
      xfer(1'b1, 8'(i));
      if (i == 0) check("win_first_addr", last_addr, 16 * 96 + 8);
      if (i == 8) check("win_row_step_addr", last_addr, 17 * 96 + 8);
      if (i == 63) check("win_last_addr", last_addr, 23 * 96 + 15);
      if (i == 64) check("win_wrap_addr", last_addr, 16 * 96 + 8);
    end
    xfer(1'b0, 8'h15); xfer(1'b0, 8'h70); xfer(1'b0, 8'h05);
    xfer(1'b0, 8'h42);
    xfer(1'b1, 8'h11);
    check("bad_window_kept_addr", last_addr, 16 * 96 + 9);
    xfer(1'b0, 8'h15);
    xfer(1'b1, 8'hE0);
    partial(5);
    xfer(1'b0, 8'hA0); xfer(1'b0, 8'h60);
    check("remap_60", remap, 8'h60);
    // asynchronous reset in the middle of a command and a partial byte
    xfer(1'b0, 8'h15);
    send_bits(1'b0, 8'hFF, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    flush();
    repeat (3) @(negedge clk);
    xfer(1'b1, 8'h5A);
    check("rst_next_addr", last_addr, 0);
    xfer(1'b1, 8'hA5);
    check("rst_second_addr", last_addr, 1);
    // synchronous panel reset in the middle of a row command
    xfer(1'b0, 8'hAF);
    xfer(1'b0, 8'h75); xfer(1'b0, 8'h20); xfer(1'b0, 8'h21);
    xfer(1'b0, 8'h75);
    send_bits(1'b0, 8'h00, 4);
    @(negedge clk);
    res = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("res_mid");
    m_reset();
    res = 1'b1;
    flush();
    repeat (3) @(negedge clk);
    xfer(1'b1, 8'h33);
    check("res_next_addr", last_addr, 0);
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) partial($urandom_range(1, 7));
      else if (r < 50) xfer(1'b1, 8'($urandom));
      else if (m_cmd != 0) xfer(1'b0, 8'($urandom_range(0, 110)));
      else begin
        cmds[5] = 8'($urandom);
        xfer(1'b0, cmds[$urandom_range(0, 5)]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
